// File: rtl/serial_shift_pkg.sv
// Shared types for the serial shifter: shift modes and FSM states.
// Pure declarations: no latency and no backpressure apply here.
package serial_shift_pkg;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROL = 2'b11
   } shift_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } shift_state_t;

endpackage

// File: rtl/serial_shift_unit_if.sv
// Request/response bus of the serial shifter, carrying valid/ready on both sides.
// Master side issues requests and consumes responses; slave side is the shifter.
interface serial_shift_unit_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] din;
   logic [AMT_W-1:0] amt;
   logic [1:0]       mode;
   logic             busy;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] dout;

   modport master (
      output req_valid, din, amt, mode, rsp_ready,
      input  req_ready, busy, rsp_valid, dout
   );

   modport slave (
      input  req_valid, din, amt, mode, rsp_ready,
      output req_ready, busy, rsp_valid, dout
   );
endinterface

// File: rtl/shift_step.sv
// Combinational single-position shift step (LSL/LSR/ASR, ROL when SERIAL_SHIFT_ROTATE_EN).
// Zero latency and no backpressure; without the macro, mode 11 takes the LSL path.
module shift_step
   import serial_shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r_i,
   input  shift_mode_t      mode_i,
   output logic [WIDTH-1:0] r_o
);

   always_comb begin
      r_o = {r_i[WIDTH-2:0], 1'b0};
      case (mode_i)
         SH_LSR:  r_o = {1'b0, r_i[WIDTH-1:1]};
         SH_ASR:  r_o = {r_i[WIDTH-1], r_i[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROTATE_EN
         SH_ROL:  r_o = {r_i[WIDTH-2:0], r_i[WIDTH-1]};
`endif
         default: r_o = {r_i[WIDTH-2:0], 1'b0};
      endcase
   end

endmodule

// File: rtl/serial_shift_unit.sv
// Serial shifter applying one bit step per clock; rsp_valid comes amt+1 cycles after the request cycle.
// One request at a time; result held in DONE until rsp_ready. Rotate mode needs SERIAL_SHIFT_ROTATE_EN.
module serial_shift_unit
   import serial_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   serial_shift_unit_if.slave bus
);

   shift_state_t     state_q, state_d;
   shift_mode_t      mode_q, mode_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] step_r;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .r_i    (r_q),
      .mode_i (mode_q),
      .r_o    (step_r)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= SH_LSL;
         r_q     <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         r_q     <= r_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               r_d     = bus.din;
               cnt_d   = bus.amt;
               mode_d  = shift_mode_t'(bus.mode);
               state_d = (bus.amt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            r_d   = step_r;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // dout only moves when a result lands, so it keeps the last result elsewhere
      dout_d = (state_d == ST_DONE) ? r_d : dout_q;
   end

   always_comb begin
      bus.req_ready = (state_q == ST_IDLE);
      bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
      bus.rsp_valid = (state_q == ST_DONE);
      bus.dout      = dout_q;
   end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit (WIDTH=8, AMT_W=3) with a cycle-level reference model.
module tb_serial_shift_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_shift_unit_if #(.WIDTH(8), .AMT_W(3)) bus ();

   serial_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // reference model: transaction-level view of the unit
   bit         m_valid = 1'b0;
   bit         m_pend  = 1'b0;
   int         m_left  = 0;
   logic [7:0] m_res   = 8'h00;
   logic [7:0] m_dout  = 8'h00;

   function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a,
                                            input logic [1:0] md);
      logic signed [7:0] s;
      int k;
      s = d;
      k = int'(a) % 8;
      case (md)
         2'b00:   return d << a;
         2'b01:   return d >> a;
         2'b10:   return 8'(s >>> a);
`ifdef SERIAL_SHIFT_ROTATE_EN
         default: return (d << k) | (d >> (8 - k));
`else
         default: return d << a;
`endif
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b0;
         m_pend  = 1'b0;
         m_dout  = 8'h00;
      end else if (m_valid) begin
         if (bus.rsp_ready) m_valid = 1'b0;
      end else if (m_pend) begin
         m_left--;
         if (m_left == 0) begin
            m_pend  = 1'b0;
            m_valid = 1'b1;
            m_dout  = m_res;
         end
      end else if (bus.req_valid) begin
         m_res = ref_shift(bus.din, bus.amt, bus.mode);
         if (bus.amt == 3'd0) begin
            m_valid = 1'b1;
            m_dout  = m_res;
         end else begin
            m_pend = 1'b1;
            m_left = int'(bus.amt);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_req_ready", 32'(bus.req_ready), 32'(!(m_valid || m_pend)));
         check("model_busy",      32'(bus.busy),      32'(m_valid || m_pend));
         check("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
         check("model_dout",      32'(bus.dout),      32'(m_dout));
      end
   end

   // Issue one request from a negedge; returns at the negedge where rsp_valid is seen.
   task automatic run_op(input string name, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] md, input logic [7:0] exp_d, input int exp_lat);
      int lat;
      bus.req_valid = 1'b1;
      bus.din       = d;
      bus.amt       = a;
      bus.mode      = md;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.din       = ~d;
      bus.amt       = ~a;
      bus.mode      = ~md;
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin
         check({name, "_busy"}, 32'(bus.busy), 32'd1);
         @(negedge clk);
         lat++;
      end
      check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({name, "_latency"},   32'(lat),           32'(exp_lat));
      check({name, "_dout"},      32'(bus.dout),      32'(exp_d));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.din       = 8'h00;
      bus.amt       = 3'd0;
      bus.mode      = 2'b00;
      bus.rsp_ready = 1'b1;
      rst           = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_dout",      32'(bus.dout),      32'd0);
      rst = 1'b0;
      @(negedge clk);

      // model sanity against hand-computed values
      check("ref_lsl", 32'(ref_shift(8'h01, 3'd3, 2'b00)), 32'h08);
      check("ref_asr", 32'(ref_shift(8'h90, 3'd2, 2'b10)), 32'hE4);
      check("ref_lsr", 32'(ref_shift(8'h80, 3'd7, 2'b01)), 32'h01);

      run_op("lsl3",   8'h01, 3'd3, 2'b00, 8'h08, 4); @(negedge clk);
      run_op("lsr7",   8'h80, 3'd7, 2'b01, 8'h01, 8); @(negedge clk);
      run_op("asr2",   8'h90, 3'd2, 2'b10, 8'hE4, 3); @(negedge clk);
      run_op("asr7",   8'h80, 3'd7, 2'b10, 8'hFF, 8); @(negedge clk);
      run_op("lsl7",   8'h81, 3'd7, 2'b00, 8'h80, 8); @(negedge clk);
      for (int m = 0; m < 4; m++) begin
         run_op("amt0", 8'hA5, 3'd0, 2'(m), 8'hA5, 1);
         @(negedge clk);
      end

      // backpressure with ignored requests while the result is pending
      bus.rsp_ready = 1'b0;
      run_op("bp", 8'h03, 3'd1, 2'b00, 8'h06, 2);
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 1'b1;
         bus.din       = 8'hFF;
         bus.amt       = 3'd2;
         bus.mode      = 2'b01;
         @(negedge clk);
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_dout",      32'(bus.dout),      32'h06);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(bus.req_ready), 32'd1);
      check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
      run_op("after_bp", 8'h3C, 3'd2, 2'b01, 8'h0F, 3); @(negedge clk);

      // reset in the middle of a shift
      bus.req_valid = 1'b1;
      bus.din       = 8'h01;
      bus.amt       = 3'd6;
      bus.mode      = 2'b00;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_dout",      32'(bus.dout),      32'd0);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      check("midrst_busy",      32'(bus.busy),      32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end

`ifdef SERIAL_SHIFT_ROTATE_EN
      run_op("mode11", 8'h81, 3'd1, 2'b11, 8'h03, 2); @(negedge clk);
      run_op("rol5",   8'h81, 3'd5, 2'b11, 8'h30, 6); @(negedge clk);
`else
      run_op("mode11", 8'h81, 3'd1, 2'b11, 8'h02, 2); @(negedge clk);
      run_op("rol5",   8'h81, 3'd5, 2'b11, 8'h20, 6); @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
